// File: rtl/dino_game_ctrl.sv
// Game-flow controller for the dino runner: input conditioning, IDLE/RUNNING/PAUSED/OVER
// sequencing, frame tick generation, restart lockout and session high score.
module dino_game_ctrl #(
  parameter int unsigned TICK_DIV      = 833333,
  parameter int unsigned LOCKOUT_TICKS = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_start,
  input  logic        btn_pause,
  input  logic        collision,
  input  logic [15:0] score_in,
  output logic        game_start,
  output logic        game_over,
  output logic        game_tick,
  output logic [1:0]  state,
  output logic [15:0] high_score,
  output logic        new_high
);

  localparam int unsigned CntW  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned LockW = (LOCKOUT_TICKS > 1) ? $clog2(LOCKOUT_TICKS + 1) : 1;
  localparam logic [CntW-1:0]  CntMax   = CntW'(TICK_DIV - 1);
  localparam logic [LockW-1:0] LockInit = LockW'(LOCKOUT_TICKS);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRunning = 2'd1,
    StPaused  = 2'd2,
    StOver    = 2'd3
  } state_e;

  logic [1:0] r_start_sync, r_pause_sync, r_coll_sync;
  logic       r_start_prev, r_pause_prev;
  logic       w_start_edge, w_pause_edge, w_coll;

  state_e           r_state, w_state_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic [LockW-1:0] r_lock, w_lock_d;
  logic             r_game_start, r_game_over, r_game_tick, r_new_high;
  logic             w_game_start_d, w_game_over_d, w_game_tick_d, w_new_high_d;
  logic [15:0]      r_high, w_high_d;
  logic             w_cnt_wrap, w_restart_ok;

  // Two-flop synchronizers plus one history flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_start_sync <= '0;
      r_pause_sync <= '0;
      r_coll_sync  <= '0;
      r_start_prev <= 1'b0;
      r_pause_prev <= 1'b0;
    end else begin
      r_start_sync <= {r_start_sync[0], btn_start};
      r_pause_sync <= {r_pause_sync[0], btn_pause};
      r_coll_sync  <= {r_coll_sync[0], collision};
      r_start_prev <= r_start_sync[1];
      r_pause_prev <= r_pause_sync[1];
    end
  end

  assign w_start_edge = r_start_sync[1] & ~r_start_prev;
  assign w_pause_edge = r_pause_sync[1] & ~r_pause_prev;
  assign w_coll       = r_coll_sync[1];
  assign w_cnt_wrap   = (r_cnt == CntMax);
  assign w_restart_ok = w_start_edge && (r_lock == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_lock       <= '0;
      r_game_start <= 1'b0;
      r_game_over  <= 1'b0;
      r_game_tick  <= 1'b0;
      r_high       <= '0;
      r_new_high   <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_lock       <= w_lock_d;
      r_game_start <= w_game_start_d;
      r_game_over  <= w_game_over_d;
      r_game_tick  <= w_game_tick_d;
      r_high       <= w_high_d;
      r_new_high   <= w_new_high_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:    if (w_start_edge) w_state_d = StRunning;
      StRunning: begin
        if (w_coll)            w_state_d = StOver;
        else if (w_pause_edge) w_state_d = StPaused;
      end
      StPaused:  if (w_pause_edge) w_state_d = StRunning;
      StOver:    if (w_restart_ok) w_state_d = StRunning;
      default:   w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_cnt_d        = r_cnt;
    w_lock_d       = r_lock;
    w_game_start_d = 1'b0;
    w_game_over_d  = 1'b0;
    w_game_tick_d  = 1'b0;
    w_high_d       = r_high;
    w_new_high_d   = r_new_high;
    unique case (r_state)
      StIdle: begin
        if (w_start_edge) begin
          w_game_start_d = 1'b1;
          w_cnt_d        = '0;
        end
      end
      StRunning: begin
        if (w_coll) begin
          // Phase restarts at OVER entry so the lockout spans whole frames.
          w_game_over_d = 1'b1;
          w_cnt_d       = '0;
          w_lock_d      = LockInit;
          if (score_in > r_high) begin
            w_high_d     = score_in;
            w_new_high_d = 1'b1;
          end
        end else begin
          w_cnt_d       = w_cnt_wrap ? '0 : r_cnt + 1'b1;
          w_game_tick_d = w_cnt_wrap & ~w_pause_edge;
        end
      end
      StPaused: begin
      end
      StOver: begin
        if (w_restart_ok) begin
          w_game_start_d = 1'b1;
          w_cnt_d        = '0;
          w_new_high_d   = 1'b0;
        end else begin
          w_cnt_d = w_cnt_wrap ? '0 : r_cnt + 1'b1;
          if (w_cnt_wrap && (r_lock != '0)) w_lock_d = r_lock - 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign game_start = r_game_start;
  assign game_over  = r_game_over;
  assign game_tick  = r_game_tick;
  assign state      = r_state;
  assign high_score = r_high;
  assign new_high   = r_new_high;

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Self-checking bench for dino_game_ctrl: directed scenarios followed by random stimulus
// compared each cycle against an event-level reference model.
module tb_dino_game_ctrl;

  localparam int TD = 4;
  localparam int LT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_start = 1'b0;
  logic        btn_pause = 1'b0;
  logic        collision = 1'b0;
  logic [15:0] score_in = '0;
  logic        game_start, game_over, game_tick, new_high;
  logic [1:0]  state;
  logic [15:0] high_score;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: state as an integer, tick phase as running cycles mod TD,
  // lockout as cycles elapsed since entering OVER.
  int m_state = 0;
  int m_phase = 0;
  int m_age   = 0;
  int m_high  = 0;
  bit m_start = 0, m_over = 0, m_tick = 0, m_nh = 0;
  bit [2:0] hs = '0, hp = '0, hc = '0;

  dino_game_ctrl #(
    .TICK_DIV      (TD),
    .LOCKOUT_TICKS (LT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_start  (btn_start),
    .btn_pause  (btn_pause),
    .collision  (collision),
    .score_in   (score_in),
    .game_start (game_start),
    .game_over  (game_over),
    .game_tick  (game_tick),
    .state      (state),
    .high_score (high_score),
    .new_high   (new_high)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit se, pe, ce;
    m_start = 0; m_over = 0; m_tick = 0;
    if (!rst_n) begin
      m_state = 0; m_phase = 0; m_age = 0; m_high = 0; m_nh = 0;
      hs = '0; hp = '0; hc = '0;
    end else begin
      // Input seen at edge k acts at edge k+2; rising edge = new 1 after a 0.
      se = hs[1] & ~hs[2];
      pe = hp[1] & ~hp[2];
      ce = hc[1];
      hs = {hs[1:0], btn_start};
      hp = {hp[1:0], btn_pause};
      hc = {hc[1:0], collision};
      case (m_state)
        0: if (se) begin m_state = 1; m_start = 1; m_phase = 0; end
        1: begin
          if (ce) begin
            m_state = 3; m_over = 1; m_age = 0;
            if (int'(score_in) > m_high) begin m_high = int'(score_in); m_nh = 1; end
          end else begin
            m_phase = (m_phase + 1) % TD;
            if (m_phase == 0 && !pe) m_tick = 1;
            if (pe) m_state = 2;
          end
        end
        2: if (pe) m_state = 1;
        default: begin
          if (se && m_age >= LT * TD) begin
            m_state = 1; m_start = 1; m_phase = 0; m_nh = 0;
          end else if (m_age < 100000) begin
            m_age++;
          end
        end
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("m_state", 32'(state), 32'(m_state));
    chk("m_start", 32'(game_start), 32'(m_start));
    chk("m_over", 32'(game_over), 32'(m_over));
    chk("m_tick", 32'(game_tick), 32'(m_tick));
    chk("m_high", 32'(high_score), 32'(m_high));
    chk("m_new_high", 32'(new_high), 32'(m_nh));
    chk("excl", 32'((32'(game_start) + 32'(game_over) + 32'(game_tick)) <= 1), 32'd1);
  endtask

  task automatic run_until(input int sel, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      cycle();
      if ((sel == 0 && game_start) || (sel == 1 && game_over) || (sel == 2 && game_tick)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_outs"}, 32'({game_start, game_over, game_tick, new_high}), 32'd0);
    chk({tag, "_high"}, 32'(high_score), 32'd0);
  endtask

  task automatic restart();
    int n;
    repeat (12) cycle();
    btn_start = 1'b1;
    run_until(0, 10, n);
    chk("restart_lat", n, 3);
    btn_start = 1'b0;
  endtask

  initial begin
    int n, ticks;

    // Reset and start
    repeat (3) cycle();
    reset_chk("rst");
    rst_n = 1'b1;
    btn_start = 1'b1;
    run_until(0, 10, n);
    chk("start_lat", n, 3);
    chk("start_state", 32'(state), 32'd1);
    btn_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      run_until(2, 10, n);
      chk("tick_period", n, TD);
    end

    // Pause with the counter frozen at 2
    repeat (3) cycle();
    btn_pause = 1'b1;
    cycle();
    chk("tick_pre_pause", 32'(game_tick), 32'd1);
    btn_pause = 1'b0;
    repeat (2) cycle();
    chk("paused_state", 32'(state), 32'd2);
    ticks = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      ticks += int'(game_tick);
    end
    chk("paused_ticks", ticks, 0);
    btn_pause = 1'b1;
    cycle();
    btn_pause = 1'b0;
    repeat (2) cycle();
    chk("resume_state", 32'(state), 32'd1);
    chk("resume_no_start", 32'(game_start), 32'd0);
    run_until(2, 10, n);
    chk("resume_tick", n, 2);

    // Game over with a new high score, then lockout
    score_in = 16'h0123;
    collision = 1'b1;
    run_until(1, 10, n);
    chk("over_lat", n, 3);
    collision = 1'b0;
    chk("over_state", 32'(state), 32'd3);
    chk("hs1", 32'(high_score), 32'h0123);
    chk("nh1", 32'(new_high), 32'd1);
    cycle();
    btn_start = 1'b1; cycle(); btn_start = 1'b0;
    repeat (3) cycle();
    btn_start = 1'b1; cycle(); btn_start = 1'b0;
    cycle();
    chk("lockout_hold", 32'(state), 32'd3);
    btn_start = 1'b1; cycle(); btn_start = 1'b0;
    cycle();
    chk("lockout_rej", 32'(state), 32'd3);
    cycle();
    chk("lockout_start", 32'(game_start), 32'd1);
    chk("lockout_state", 32'(state), 32'd1);
    chk("lockout_nh_clr", 32'(new_high), 32'd0);

    // Lower score, then tie
    score_in = 16'h0100;
    collision = 1'b1;
    run_until(1, 10, n);
    collision = 1'b0;
    chk("hs2", 32'(high_score), 32'h0123);
    chk("nh2", 32'(new_high), 32'd0);
    restart();
    score_in = 16'h0123;
    collision = 1'b1;
    run_until(1, 10, n);
    collision = 1'b0;
    chk("hs_tie", 32'(high_score), 32'h0123);
    chk("nh_tie", 32'(new_high), 32'd0);

    // Collision and pause together at counter TD-1
    restart();
    cycle();
    btn_pause = 1'b1;
    collision = 1'b1;
    repeat (3) cycle();
    chk("simul_over", 32'(game_over), 32'd1);
    chk("simul_tick", 32'(game_tick), 32'd0);
    chk("simul_state", 32'(state), 32'd3);
    btn_pause = 1'b0;
    collision = 1'b0;

    // Reset while PAUSED and during lockout
    restart();
    btn_pause = 1'b1;
    repeat (3) cycle();
    chk("pre_rst_paused", 32'(state), 32'd2);
    btn_pause = 1'b0;
    rst_n = 1'b0;
    cycle();
    reset_chk("rst_paused");
    rst_n = 1'b1;
    btn_start = 1'b1;
    run_until(0, 10, n);
    chk("post_rst_start", n, 3);
    btn_start = 1'b0;
    score_in = 16'h0055;
    collision = 1'b1;
    run_until(1, 10, n);
    chk("post_rst_over", n, 3);
    collision = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b0;
    cycle();
    reset_chk("rst_over");
    rst_n = 1'b1;

    // Random stimulus against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0)  btn_start = ~btn_start;
      if ($urandom_range(0, 15) == 0) btn_pause = ~btn_pause;
      if ($urandom_range(0, 40) == 0) collision = ~collision;
      score_in = 16'($urandom_range(0, 1023));
      rst_n = ($urandom_range(0, 499) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
